// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands, issues one per cycle to a registered
// ALU, tags each issue with a token that tracks the ALU latency, and collects
// the tagged results into an in-order result FIFO guarded by slot credits.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer may not retract valid before the transfer. Ready
// never depends combinationally on valid (o_cmd_ready is !cmd_full and
// o_res_valid is !res_empty, both purely registered).
module alu_issue_queue #(
  parameter int N       = 4,
  parameter int M       = 8,
  parameter int K       = 8,
  parameter int DEPTH   = 4,
  parameter int RDEPTH  = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [N-1:0] i_cmd_op,
  input  logic [M-1:0] i_cmd_A,
  input  logic [M-1:0] i_cmd_B,
  output logic [N-1:0] o_alu_op,
  output logic [M-1:0] o_alu_A,
  output logic [M-1:0] o_alu_B,
  input  logic [K-1:0] i_alu_result,
  input  logic [3:0]   i_alu_status,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [K-1:0] o_res_data,
  output logic [3:0]   o_res_status,
  output logic         o_busy
);

  localparam int CW  = N + 2 * M;
  localparam int RW  = K + 4;
  localparam int CAW = $clog2(DEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int IFW = $clog2(ALU_LAT + 2);

  logic [CW-1:0]    cmd_mem_q [DEPTH];
  logic [CAW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CAW:0]     cmd_cnt_q, cmd_cnt_d;

  logic [RW-1:0]    res_mem_q [RDEPTH];
  logic [RAW-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  logic [RAW:0]     res_cnt_q, res_cnt_d;

  logic [ALU_LAT:0] tok_q, tok_d;
  logic [IFW-1:0]   inflight_q, inflight_d;

  logic [N-1:0]     alu_op_q, alu_op_d;
  logic [M-1:0]     alu_a_q, alu_a_d;
  logic [M-1:0]     alu_b_q, alu_b_d;

  logic             cmd_full, res_full, credit_ok;
  logic             push, issue, capture, pop;
  logic [RW-1:0]    res_head;

  // Handshake and credit decisions from registered state only.
  always_comb begin
    cmd_full  = (cmd_cnt_q == (CAW + 1)'(DEPTH));
    res_full  = (res_cnt_q == (RAW + 1)'(RDEPTH));
    // A result slot is reserved at issue time so capture can never overflow.
    credit_ok = (32'(res_cnt_q) + 32'(inflight_q)) < 32'(RDEPTH);
    push      = i_cmd_valid && !cmd_full;
    issue     = (cmd_cnt_q != '0) && credit_ok;
    // The oldest token stage marks the edge at which the ALU result is valid.
    capture   = tok_q[ALU_LAT];
    pop       = (res_cnt_q != '0) && i_res_ready;
  end

  // Next-state for pointers, counts, the token pipe and the ALU drive registers.
  always_comb begin
    cmd_wr_d   = cmd_wr_q + CAW'(push);
    cmd_rd_d   = cmd_rd_q + CAW'(issue);
    cmd_cnt_d  = cmd_cnt_q + (CAW + 1)'(push) - (CAW + 1)'(issue);
    res_wr_d   = res_wr_q + RAW'(capture);
    res_rd_d   = res_rd_q + RAW'(pop);
    res_cnt_d  = res_cnt_q + (RAW + 1)'(capture) - (RAW + 1)'(pop);
    tok_d      = {tok_q[ALU_LAT-1:0], issue};
    inflight_d = inflight_q + IFW'(issue) - IFW'(capture);
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    // Without an issue the ALU inputs hold; its untagged output is ignored.
    if (issue) begin
      {alu_op_d, alu_a_d, alu_b_d} = cmd_mem_q[cmd_rd_q];
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      tok_q      <= '0;
      inflight_q <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      res_cnt_q  <= res_cnt_d;
      tok_q      <= tok_d;
      inflight_q <= inflight_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

  // Command storage; contents need no reset because the count gates reads.
  always_ff @(posedge i_clk) begin
    if (push) begin
      cmd_mem_q[cmd_wr_q] <= {i_cmd_op, i_cmd_A, i_cmd_B};
    end
  end

  // Result storage; captures the ALU output when a tagged token retires.
  always_ff @(posedge i_clk) begin
    if (capture && !i_reset) begin
      res_mem_q[res_wr_q] <= {i_alu_status, i_alu_result};
    end
  end

  // Credits make a capture into a full result FIFO impossible.
  res_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(capture && res_full));

  // Output drive.
  always_comb begin
    res_head     = res_mem_q[res_rd_q];
    o_cmd_ready  = !cmd_full;
    o_alu_op     = alu_op_q;
    o_alu_A      = alu_a_q;
    o_alu_B      = alu_b_q;
    o_res_valid  = (res_cnt_q != '0);
    o_res_data   = res_head[K-1:0];
    o_res_status = res_head[RW-1:K];
    o_busy       = (cmd_cnt_q != '0) || (inflight_q != '0) || (res_cnt_q != '0);
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: a stand-in registered ALU, a transaction-level
// model of the queue built from SystemVerilog queues, a per-cycle compare
// process, directed scenarios with literal expectations, and random traffic.
module tb_alu_issue_queue;

  localparam int N = 4, M = 8, K = 8, DEPTH = 4, RDEPTH = 4, ALU_LAT = 1;
  localparam int CW = N + 2 * M;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [N-1:0] cmd_op = '0;
  logic [M-1:0] cmd_a = '0, cmd_b = '0;
  logic [N-1:0] alu_op;
  logic [M-1:0] alu_a, alu_b;
  logic [K-1:0] alu_res_q = '0;
  logic [3:0]   alu_st_q = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [K-1:0] res_data;
  logic [3:0]   res_status;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  alu_issue_queue #(.N(N), .M(M), .K(K), .DEPTH(DEPTH), .RDEPTH(RDEPTH),
                    .ALU_LAT(ALU_LAT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_A(cmd_a), .i_cmd_B(cmd_b),
    .o_alu_op(alu_op), .o_alu_A(alu_a), .o_alu_B(alu_b),
    .i_alu_result(alu_res_q), .i_alu_status(alu_st_q),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_status(res_status),
    .o_busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stand-in ALU (one registered stage) ----------------
  function automatic logic [K-1:0] f_res(logic [N-1:0] op, logic [M-1:0] a, logic [M-1:0] b);
    logic [K-1:0] s;
    s = a + b;
    return s ^ {op, op};
  endfunction

  function automatic logic [3:0] f_st(logic [N-1:0] op);
    return op ^ 4'h5;
  endfunction

  always @(posedge clk) begin
    alu_res_q <= f_res(alu_op, alu_a, alu_b);
    alu_st_q  <= f_st(alu_op);
  end

  // ---------------- transaction-level model ----------------
  logic [CW-1:0]    cmd_q[$];     // accepted, not yet issued
  logic [CW-1:0]    pipe_cmd[$];  // issued, result not yet captured
  int               pipe_age[$];  // edges since issue
  logic [K+3:0]     exp_q[$];     // {status, result} awaiting the consumer
  logic [CW-1:0]    exp_alu = '0;
  logic [CW-1:0]    m_c;
  int               acc_cnt = 0;
  int               pop_cnt = 0;
  bit               do_push, do_issue, do_cap, do_pop;

  always @(posedge clk) begin
    if (rst) begin
      cmd_q.delete();
      pipe_cmd.delete();
      pipe_age.delete();
      exp_q.delete();
      exp_alu = '0;
    end else begin
      do_push  = cmd_valid && (cmd_q.size() < DEPTH);
      do_issue = (cmd_q.size() > 0) && ((exp_q.size() + pipe_cmd.size()) < RDEPTH);
      do_cap   = (pipe_age.size() > 0) && (pipe_age[0] == ALU_LAT);
      do_pop   = (exp_q.size() > 0) && res_ready;
      foreach (pipe_age[i]) pipe_age[i]++;
      if (do_pop) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (do_cap) begin
        m_c = pipe_cmd.pop_front();
        void'(pipe_age.pop_front());
        exp_q.push_back({f_st(m_c[CW-1:2*M]), f_res(m_c[CW-1:2*M], m_c[2*M-1:M], m_c[M-1:0])});
      end
      if (do_issue) begin
        m_c = cmd_q.pop_front();
        pipe_cmd.push_back(m_c);
        pipe_age.push_back(0);
        exp_alu = m_c;
      end
      if (do_push) begin
        cmd_q.push_back({cmd_op, cmd_a, cmd_b});
        acc_cnt++;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(cmd_q.size() < DEPTH));
      chk("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("res_head", 32'({res_status, res_data}), 32'(exp_q[0]));
      chk("alu_drive", 32'({alu_op, alu_a, alu_b}), 32'(exp_alu));
      chk("busy", 32'(busy), 32'((cmd_q.size() + pipe_cmd.size() + exp_q.size()) != 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(logic v, logic [N-1:0] op, logic [M-1:0] a, logic [M-1:0] b);
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_idle", 32'(busy), 32'(0));
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    chk({tag, "_res_valid"}, 32'(res_valid), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_alu"}, 32'({alu_op, alu_a, alu_b}), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_valid, n_valid, n_ready, idx, acc0, pop0, sent;

    // reset
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk_reset_values("rst");
    rst = 1'b0;

    // single command, consumer held off so the result stays visible
    res_ready = 1'b0;
    set_cmd(1'b1, 4'h0, 8'hCC, 8'hFE);
    @(negedge clk);                       // E0 push
    set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
    @(negedge clk);                       // E1 issue
    chk("single_alu", 32'({alu_op, alu_a, alu_b}), 32'(20'h0CCFE));
    @(negedge clk);                       // E2 ALU samples
    chk("single_not_yet", 32'(res_valid), 32'(0));
    @(negedge clk);                       // E3 capture
    chk("single_valid", 32'(res_valid), 32'(1));
    chk("single_data", 32'(res_data), 32'(8'hCA));
    chk("single_status", 32'(res_status), 32'(4'h5));
    res_ready = 1'b1;
    @(negedge clk);
    chk("single_popped", 32'(res_valid), 32'(0));

    // back-to-back stream of 8
    first_valid = -1;
    n_valid = 0;
    n_ready = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        set_cmd(1'b1, 4'(c), 8'(c + 1), 8'h30);
        if (cmd_ready) n_ready++;
      end else begin
        set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
      end
      @(negedge clk);
      if (res_valid) begin
        if (first_valid < 0) first_valid = c;
        n_valid++;
      end
    end
    chk("stream_ready_cycles", 32'(n_ready), 32'(8));
    chk("stream_first_result", 32'(first_valid), 32'(3));
    chk("stream_result_cycles", 32'(n_valid), 32'(8));
    wait_idle();

    // backpressure: offer 10, expect 8 accepted
    res_ready = 1'b0;
    acc0 = acc_cnt;
    pop0 = pop_cnt;
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      set_cmd(idx < 10, 4'(idx), 8'h10 + 8'(idx), 8'(c));
      if (idx < 10 && cmd_ready) idx++;
      @(negedge clk);
    end
    chk("bp_accepted_model", 32'(acc_cnt - acc0), 32'(8));
    chk("bp_accepted_seen", 32'(idx), 32'(8));
    chk("bp_cmd_ready_low", 32'(cmd_ready), 32'(0));

    // full command FIFO: one pop frees a credit, issue then coincides with a push attempt
    set_cmd(1'b1, 4'hA, 8'h55, 8'hAA);
    res_ready = 1'b1;
    @(negedge clk);                       // pop only
    res_ready = 1'b0;
    chk("sim_still_full", 32'(cmd_ready), 32'(0));
    @(negedge clk);                       // issue + rejected push
    chk("sim_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("sim_cmd_count", 32'(cmd_q.size()), 32'(DEPTH - 1));
    chk("sim_push_rejected", 32'(acc_cnt - acc0), 32'(8));
    set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
    res_ready = 1'b1;
    wait_idle();
    chk("bp_drained", 32'(pop_cnt - pop0), 32'(8));

    // reset mid-flight: 3 results parked, 1 in flight, 2 queued
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_cmd(1'b1, 4'h3, 8'(8'h40 + c), 8'h01);
      @(negedge clk);
    end
    set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      set_cmd(1'b1, 4'h6, 8'(8'h70 + c), 8'h02);
      @(negedge clk);
    end
    set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
    chk("mid_queued", 32'(cmd_q.size()), 32'(2));
    chk("mid_inflight", 32'(pipe_cmd.size()), 32'(1));
    chk("mid_parked", 32'(exp_q.size()), 32'(3));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_values("midrst");
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("midrst_quiet", 32'(res_valid), 32'(0));
    end

    // pointer wrap: 3*DEPTH commands with 2-on/1-off consumer
    pop0 = pop_cnt;
    sent = 0;
    for (int c = 0; c < 200 && sent < 3 * DEPTH; c++) begin
      res_ready = (c % 3) != 2;
      set_cmd(1'b1, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)));
      if (cmd_ready) sent++;
      @(negedge clk);
    end
    set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
    res_ready = 1'b1;
    wait_idle();
    chk("wrap_results", 32'(pop_cnt - pop0), 32'(3 * DEPTH));

    // random traffic with occasional reset
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      set_cmd($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(negedge clk);
    end
    rst = 1'b0;
    set_cmd(1'b0, 4'h0, 8'h00, 8'h00);
    res_ready = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
